// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: instruction field widths,
// the next-PC source enumeration and the branch target helper.
package pc_sequencer_pkg;

    // Width of the signed word offset carried by a conditional branch.
    localparam int OFFSET_W = 16;

    // Width of the pseudo-direct jump target field inst[25:0].
    localparam int TARGET_W = 26;

    // Widest address the branch helper works on; callers cast to and from it.
    localparam int MAX_W = 128;

    // Source chosen for the next PC value.
    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_J    = 3'd2,
        SEL_JR   = 3'd3,
        SEL_RAS  = 3'd4,
        SEL_HOLD = 3'd5
    } next_sel_e;

    // Branch target: the word offset is sign-extended and scaled to bytes,
    // then added to pc+4. The caller keeps the low WIDTH bits, which gives
    // wrap-around modulo 2^WIDTH.
    function automatic logic [MAX_W-1:0] branch_target(
        input logic [MAX_W-1:0]    pc_plus4,
        input logic [OFFSET_W-1:0] offset
    );
        logic [MAX_W-1:0] byte_offset;
        byte_offset = {{(MAX_W-OFFSET_W-2){offset[OFFSET_W-1]}}, offset, 2'b00};
        return pc_plus4 + byte_offset;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of the control inputs and PC/RAS outputs of the PC sequencer.
// The master side is the pipeline that drives the redirects; the slave side
// is the sequencer itself.
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
);

    logic                stall;
    logic                branch_taken;
    logic [OFFSET_W-1:0] branch_offset;
    logic                jump;
    logic [TARGET_W-1:0] jump_target;
    logic                jump_link;
    logic                jr;
    logic [WIDTH-1:0]    jr_addr;
    logic                jr_use_ras;
    logic [WIDTH-1:0]    pc;
    logic [WIDTH-1:0]    pc_plus4;
    logic                ras_empty;
    logic                ras_full;

    modport master (
        output stall,
        output branch_taken,
        output branch_offset,
        output jump,
        output jump_target,
        output jump_link,
        output jr,
        output jr_addr,
        output jr_use_ras,
        input  pc,
        input  pc_plus4,
        input  ras_empty,
        input  ras_full
    );

    modport slave (
        input  stall,
        input  branch_taken,
        input  branch_offset,
        input  jump,
        input  jump_target,
        input  jump_link,
        input  jr,
        input  jr_addr,
        input  jr_use_ras,
        output pc,
        output pc_plus4,
        output ras_empty,
        output ras_full
    );

endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack. The pointer always names the next slot to
// write, so the top of stack sits one slot below it. Pushing into a full
// stack writes over the oldest entry, which is exactly the slot the pointer
// names once the stack has wrapped.
module ras_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // A pop into an empty stack is ignored; push wins if both ever arrive.
    assign do_push = push;
    assign do_pop  = pop && !push && !empty;

    // Neighbouring pointer values with wrap at RAS_DEPTH, which need not be
    // a power of two.
    always_comb begin
        ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
        ptr_dec = (ptr == '0) ? PTR_LAST : ptr - PTR_W'(1);
    end

    assign top = mem[ptr_dec];

    // Pointer and occupancy; the count saturates at both ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (do_push) begin
            ptr <= ptr_inc;
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (do_pop) begin
            ptr   <= ptr_dec;
            count <= count - CNT_W'(1);
        end
    end

    // Entry storage; contents are left alone on reset because nothing can
    // read them until a push has refilled the slot.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: holds the PC register, forms the branch, jump
// and register-jump targets, and picks the next PC by fixed priority
// (stall, jr, jump, branch, sequential). Return addresses for JAL are kept
// in a small circular stack so JR $ra can be predicted without the register.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.slave bus
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] j_target;
    logic [WIDTH-1:0] jr_target;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_push;
    logic             ras_pop;
    next_sel_e        sel;

    assign pc_plus4 = pc_q + WIDTH'(4);

    assign br_target = WIDTH'(branch_target(MAX_W'(pc_plus4), bus.branch_offset));

    // The jump keeps the top four bits of pc+4 and splices in the field.
    assign j_target = {pc_plus4[WIDTH-1:28], bus.jump_target, 2'b00};

    // Register operand with the byte offset bits cleared.
    assign jr_target = bus.jr_addr & ~WIDTH'(3);

    // JAL links only when nothing of higher priority claims the cycle; a
    // return consumes the stack only when it actually takes the stacked value.
    assign ras_push = bus.jump && bus.jump_link && !bus.jr && !bus.stall;
    assign ras_pop  = bus.jr && bus.jr_use_ras && !ras_empty && !bus.stall;

    // Pick the next-PC source by priority.
    always_comb begin
        sel = SEL_SEQ;
        if (bus.stall) begin
            sel = SEL_HOLD;
        end else if (bus.jr) begin
            sel = (bus.jr_use_ras && !ras_empty) ? SEL_RAS : SEL_JR;
        end else if (bus.jump) begin
            sel = SEL_J;
        end else if (bus.branch_taken) begin
            sel = SEL_BR;
        end
    end

    // Route the selected target onto the next-PC bus.
    always_comb begin
        pc_next = pc_plus4;
        case (sel)
            SEL_HOLD: pc_next = pc_q;
            SEL_RAS:  pc_next = ras_top;
            SEL_JR:   pc_next = jr_target;
            SEL_J:    pc_next = j_target;
            SEL_BR:   pc_next = br_target;
            default:  pc_next = pc_plus4;
        endcase
    end

    // PC register; reset beats every other request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_plus4),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random traffic.
// Each stimulus cycle pushes the expected post-edge state into a scoreboard
// queue; an independent monitor pops and compares after every rising edge.
module tb_pc_sequencer;

    localparam int          WIDTH     = 32;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] RESET_VAL = 32'h0;

    typedef struct {
        logic [31:0] pc;
        bit          empty;
        bit          full;
        string       name;
    } exp_t;

    logic clk;
    logic rst;

    pc_sequencer_if #(.WIDTH(WIDTH)) bus ();

    pc_sequencer #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (DEPTH),
        .RESET_PC  (RESET_VAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference state: the PC and the return stack as a plain queue
    // (back = newest).
    logic [31:0] m_pc;
    logic [31:0] ras_model[$];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one scoreboard entry against what the DUT shows now.
    task automatic checkOutput(input exp_t e);
        checks++;
        if (bus.pc !== e.pc) begin
            errors++;
            $display("[TB] FAIL %s pc: got %h want %h", e.name, bus.pc, e.pc);
        end
        checks++;
        if (bus.pc_plus4 !== e.pc + 32'd4) begin
            errors++;
            $display("[TB] FAIL %s pc_plus4: got %h want %h", e.name, bus.pc_plus4, e.pc + 32'd4);
        end
        checks++;
        if (bus.ras_empty !== e.empty) begin
            errors++;
            $display("[TB] FAIL %s ras_empty: got %b want %b", e.name, bus.ras_empty, e.empty);
        end
        checks++;
        if (bus.ras_full !== e.full) begin
            errors++;
            $display("[TB] FAIL %s ras_full: got %b want %b", e.name, bus.ras_full, e.full);
        end
    endtask

    // Monitor: the PC is presented every cycle, so consume one entry per edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                checkOutput(sb.pop_front());
            end
        end
    end

    // Drive one cycle of inputs, advance the reference, queue the expectation.
    // When use_exp is set the queued PC is the given constant instead of the
    // model result, so hand-derived values are checked directly.
    task automatic applyStimulus(
        input bit          r,
        input bit          st,
        input bit          br,
        input logic [15:0] off,
        input bit          j,
        input logic [25:0] tgt,
        input bit          lnk,
        input bit          jrr,
        input logic [31:0] ja,
        input bit          ur,
        input string       name,
        input bit          use_exp,
        input logic [31:0] exp_pc
    );
        logic [31:0] nxt;
        exp_t        e;
        @(negedge clk);
        rst               = r;
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_offset = off;
        bus.jump          = j;
        bus.jump_target   = tgt;
        bus.jump_link     = lnk;
        bus.jr            = jrr;
        bus.jr_addr       = ja;
        bus.jr_use_ras    = ur;

        if (r) begin
            nxt = RESET_VAL;
            ras_model.delete();
        end else if (st) begin
            nxt = m_pc;
        end else if (jrr) begin
            if (ur && ras_model.size() > 0) begin
                nxt = ras_model.pop_back();
            end else begin
                nxt = ja - (ja % 4);
            end
        end else if (j) begin
            nxt = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(tgt) * 32'd4);
            if (lnk) begin
                ras_model.push_back(m_pc + 32'd4);
                if (ras_model.size() > DEPTH) begin
                    void'(ras_model.pop_front());
                end
            end
        end else if (br) begin
            nxt = m_pc + 32'd4 + 32'(int'($signed(off)) * 4);
        end else begin
            nxt = m_pc + 32'd4;
        end
        m_pc = nxt;

        e.pc    = use_exp ? exp_pc : nxt;
        e.empty = (ras_model.size() == 0);
        e.full  = (ras_model.size() == DEPTH);
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic doSeq(input string name, input logic [31:0] exp_pc);
        applyStimulus(0, 0, 0, 16'h0, 0, 26'h0, 0, 0, 32'h0, 0, name, 1, exp_pc);
    endtask

    task automatic doJr(input logic [31:0] ja, input bit ur, input string name,
                        input logic [31:0] exp_pc);
        applyStimulus(0, 0, 0, 16'h0, 0, 26'h0, 0, 1, ja, ur, name, 1, exp_pc);
    endtask

    task automatic doJump(input logic [25:0] tgt, input bit lnk, input string name,
                          input logic [31:0] exp_pc);
        applyStimulus(0, 0, 0, 16'h0, 1, tgt, lnk, 0, 32'h0, 0, name, 1, exp_pc);
    endtask

    task automatic doBranch(input logic [15:0] off, input string name,
                            input logic [31:0] exp_pc);
        applyStimulus(0, 0, 1, off, 0, 26'h0, 0, 0, 32'h0, 0, name, 1, exp_pc);
    endtask

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_offset = '0;
        bus.jump = 1'b0;
        bus.jump_target = '0;
        bus.jump_link = 1'b0;
        bus.jr = 1'b0;
        bus.jr_addr = '0;
        bus.jr_use_ras = 1'b0;
        m_pc = RESET_VAL;

        // Reset and free-run.
        applyStimulus(1, 0, 0, 16'h0, 0, 26'h0, 0, 0, 32'h0, 0, "reset0", 1, 32'h0);
        applyStimulus(1, 0, 0, 16'h0, 0, 26'h0, 0, 0, 32'h0, 0, "reset1", 1, 32'h0);
        doSeq("run4", 32'h4);
        doSeq("run8", 32'h8);
        doSeq("run12", 32'hC);

        // Branches from 0x100.
        doJr(32'h100, 0, "jr_to_100", 32'h100);
        doBranch(16'hFFFF, "branch_back", 32'h100);
        doBranch(16'h0003, "branch_fwd", 32'h110);

        // Jump concatenation keeps the region bits of pc+4.
        doJr(32'h3000_0000, 0, "jr_to_3000", 32'h3000_0000);
        doJump(26'h40, 0, "jump_concat", 32'h3000_0100);

        // Three nested calls and returns.
        doJr(32'h10, 0, "jr_to_10", 32'h10);
        doJump(26'h8, 1, "jal_10", 32'h20);
        doJump(26'hC, 1, "jal_20", 32'h30);
        doJump(26'h10, 1, "jal_30", 32'h40);
        doJr(32'h0BAD_0000, 1, "ret_34", 32'h34);
        doJr(32'h0BAD_0000, 1, "ret_24", 32'h24);
        doJr(32'h0BAD_0000, 1, "ret_14", 32'h14);
        doJr(32'h0BAD_0000, 1, "ret_empty", 32'h0BAD_0000);

        // Overflow: five calls into a four-entry stack.
        doJr(32'h200, 0, "jr_to_200", 32'h200);
        doJump(26'hC0, 1, "ovf_jal1", 32'h300);
        doJump(26'h100, 1, "ovf_jal2", 32'h400);
        doJump(26'h140, 1, "ovf_jal3", 32'h500);
        doJump(26'h180, 1, "ovf_jal4", 32'h600);
        doJump(26'h1C0, 1, "ovf_jal5", 32'h700);
        doJr(32'hDEAD_BEE0, 1, "ovf_ret1", 32'h604);
        doJr(32'hDEAD_BEE0, 1, "ovf_ret2", 32'h504);
        doJr(32'hDEAD_BEE0, 1, "ovf_ret3", 32'h404);
        doJr(32'hDEAD_BEE0, 1, "ovf_ret4", 32'h304);
        doJr(32'hDEAD_BEE0, 1, "ovf_ret5", 32'hDEAD_BEE0);

        // Collisions.
        doJump(26'h40, 1, "jal_region_d", 32'hD000_0100);
        applyStimulus(0, 0, 1, 16'h0010, 1, 26'h123, 1, 1, 32'h0000_0803, 0,
                      "jr_beats_all", 1, 32'h800);
        applyStimulus(0, 1, 0, 16'h0, 1, 26'h99, 1, 0, 32'h0, 0,
                      "stall_jal", 1, 32'h800);
        doJr(32'h0, 1, "ret_after_coll", 32'hDEAD_BEE4);
        applyStimulus(1, 0, 0, 16'h0, 1, 26'h77, 1, 0, 32'h0, 0,
                      "rst_jump", 1, RESET_VAL);
        doSeq("post_rst", 32'h4);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) < 2),
                          ($urandom_range(0, 99) < 10),
                          ($urandom_range(0, 99) < 30),
                          16'($urandom()),
                          ($urandom_range(0, 99) < 25),
                          26'($urandom()),
                          ($urandom_range(0, 99) < 60),
                          ($urandom_range(0, 99) < 20),
                          $urandom(),
                          ($urandom_range(0, 99) < 75),
                          "random", 0, 32'h0);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, meaning address width in bits; legal values are at least 32.
REQ-002 Parameter RAS_DEPTH, default 4, meaning return-address-stack entries; legal values are 2..16.
REQ-003 Parameter RESET_PC, default 0, meaning the PC value loaded on reset; it is word-aligned.
REQ-004 clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  meaning reset; synchronous and active-high.
REQ-006 stall  input  1  meaning hold the PC and the RAS this cycle.
REQ-007 branch_taken  input  1  meaning a conditional branch resolved as taken.
REQ-008 branch_offset  input  16  meaning the signed word offset of the branch.
REQ-009 jump  input  1  meaning a pseudo-direct jump (J/JAL).
REQ-010 jump_target  input  26  meaning the instruction target field inst[25:0].
REQ-011 jump_link  input  1  meaning the jump is JAL; it is qualified by jump.
REQ-012 jr  input  1  meaning a register-indirect jump.
REQ-013 jr_addr  input  WIDTH  meaning the register operand of JR.
REQ-014 jr_use_ras  input  1  meaning the JR is a return ($ra); take the target from the RAS when the RAS is non-empty.
REQ-015 pc  output  WIDTH  meaning the current PC (registered).
REQ-016 pc_plus4  output  WIDTH  meaning pc+4, combinational.
REQ-017 ras_empty / ras_full  output  1 each  meaning the RAS occupancy flags.

Function
REQ-018 The next-PC priority is: rst, then stall (hold), then jr, then jump, then branch_taken, then pc_plus4.
REQ-019 Branch target = pc_plus4 + (sign-extend(branch_offset) << 2), with arithmetic modulo 2^WIDTH.
REQ-020 Jump target = {pc_plus4[WIDTH-1:28], jump_target, 2'b00}, formed by concatenation and never by addition.
REQ-021 JR target = RAS top if (jr_use_ras && !ras_empty), else jr_addr with bits [1:0] forced to 0.
REQ-022 Latency is one cycle: a redirect asserted in cycle N appears on pc in cycle N+1.
REQ-023 A push occurs when jump && jump_link && !jr && !stall; the pushed value is pc_plus4.
REQ-024 A pop occurs when jr && jr_use_ras && !ras_empty && !stall; the popped entry is the JR target.
REQ-025 Push when full: the circular stack overwrites the oldest entry, the count stays RAS_DEPTH, and ras_full stays 1.
REQ-026 Pop when empty: no pop occurs, the target is jr_addr, and the count stays 0.
REQ-027 When jr and jump_link are asserted together, jr wins and no push occurs.
REQ-028 The RAS pointer wraps modulo RAS_DEPTH; the occupancy count saturates at 0..RAS_DEPTH.
REQ-029 ras_empty = (count==0) and ras_full = (count==RAS_DEPTH); both are derived from registered state.

Reset
REQ-030 On rst, pc = RESET_PC, count = 0, and the pointer = 0; ras_empty = 1 and ras_full = 0 on the following cycle.
REQ-031 rst overrides stall and all redirects in the same cycle, and any in-flight push or pop is discarded.
REQ-032 RAS entry contents need not be cleared on reset; they are unobservable while count = 0.

Structure
REQ-033 The shared package holds the field widths (OFFSET_W = 16, TARGET_W = 26), the next-PC select enumeration (SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_RAS, SEL_HOLD), and a function for the branch target.
REQ-034 The RAS is one sub-module, ras_stack (parameters WIDTH and RAS_DEPTH; ports push, pop, din, top, empty, full).
REQ-035 pc_sequencer holds the PC register, the target arithmetic, and the priority select only.

Verification
REQ-036 Reset then free-run: pc = 0, 4, 8, 12 on consecutive cycles; ras_empty = 1.
REQ-037 Branch: pc = 0x100, branch_taken, offset = 0xFFFF -> pc = 0x100; offset = 0x0003 from 0x100 -> pc = 0x110.
REQ-038 Jump concatenation: pc = 0x3000_0000, jump, target = 0x000_0040 -> pc = 0x3000_0100, not a sum.
REQ-039 RAS LIFO: JAL at 0x10, 0x20, 0x30; then three JR returns -> pc = 0x34, 0x24, 0x14; then ras_empty = 1.
REQ-040 Overflow with RAS_DEPTH = 4: five JALs, then five returns with jr_addr = 0xDEAD_BEE0 -> four RAS targets (newest to second-oldest), then 0xDEAD_BEE0.
REQ-041 Collisions: jr+jump+branch_taken together -> jr target taken; stall asserted with JAL -> pc held and RAS unchanged; rst with jump -> pc = RESET_PC.
